// File: rtl/memarb_pkg.sv
// Shared types and constants for the IFU/LSU single-port memory arbiter.
package memarb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // One-hot grant encoding produced by memarb_pick: bit0 IFU, bit1 LSU.
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_IFU  = 2'b01;
   localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/memarb_pick.sv
// Combinational winner selection: on a tie the requester not granted last wins.
module memarb_pick
   import memarb_pkg::*;
(
   input  logic       ifu_valid_i,
   input  logic       lsu_valid_i,
   input  owner_e     last_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = GNT_NONE;
      if (ifu_valid_i && lsu_valid_i) begin
         grant_o = (last_i == OWN_IFU) ? GNT_LSU : GNT_IFU;
      end else if (lsu_valid_i) begin
         grant_o = GNT_LSU;
      end else if (ifu_valid_i) begin
         grant_o = GNT_IFU;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU, LSU) arbiter onto one memory port, one transaction outstanding.
// Define MEMARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed LSU priority.
//
// state | meaning
// IDLE  | accepting; ready goes to one winner, request fields latched
// REQ   | mem_req_valid high with latched fields until mem_req_ready
// WAIT  | waiting for mem_rsp_valid; response routed to the owner
module mem_arbiter
   import memarb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rsp_valid,

   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [31:0]       lsu_wdata,
   input  logic [3:0]        lsu_wmask,
   output logic              lsu_rsp_valid,

   output logic [31:0]       rsp_data,

   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data
);

   state_e            st_q;
   owner_e            owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wmask_q;

   owner_e            last_owner;
   logic [1:0]        grant;
   logic              idle;
   logic              accept;
   logic              rsp_fire;

   memarb_pick u_pick (
      .ifu_valid_i (ifu_req_valid),
      .lsu_valid_i (lsu_req_valid),
      .last_i      (last_owner),
      .grant_o     (grant)
   );

`ifdef MEMARB_ROUND_ROBIN_EN
   owner_e last_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= OWN_IFU;
      end else if (accept) begin
         last_q <= grant[1] ? OWN_LSU : OWN_IFU;
      end
   end

   assign last_owner = last_q;
`else
   // Pinning "IFU last" makes the picker degenerate to fixed LSU priority.
   assign last_owner = OWN_IFU;
`endif

   // Gated by reset so no ready can escape while reset is held.
   assign idle          = reset && (st_q == IDLE);
   assign accept        = idle && (ifu_req_valid || lsu_req_valid);
   assign ifu_req_ready = idle && grant[0];
   assign lsu_req_ready = idle && grant[1];

   assign rsp_fire      = (st_q == WAIT) && mem_rsp_valid;
   assign ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
   assign lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
   assign rsp_data      = (rsp_fire && !wen_q) ? mem_rsp_data : 32'h0;

   assign mem_req_valid = (st_q == REQ);
   assign mem_addr      = (st_q == REQ) ? addr_q  : '0;
   assign mem_wen       = (st_q == REQ) ? wen_q   : 1'b0;
   assign mem_wdata     = (st_q == REQ) ? wdata_q : 32'h0;
   assign mem_wmask     = (st_q == REQ) ? wmask_q : 4'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= IDLE;
         owner_q <= OWN_IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= 32'h0;
         wmask_q <= 4'h0;
      end else begin
         case (st_q)
            IDLE: begin
               if (accept) begin
                  st_q <= REQ;
                  if (grant[1]) begin
                     owner_q <= OWN_LSU;
                     addr_q  <= lsu_addr;
                     wen_q   <= lsu_wen;
                     wdata_q <= lsu_wdata;
                     wmask_q <= lsu_wmask;
                  end else begin
                     owner_q <= OWN_IFU;
                     addr_q  <= ifu_addr;
                     wen_q   <= 1'b0;
                     wdata_q <= 32'h0;
                     wmask_q <= 4'h0;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  st_q <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  st_q <= IDLE;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default fixed-priority build).
module tb_mem_arbiter;
   import memarb_pkg::*;

   logic        clk;
   logic        reset;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_addr;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic [31:0] rsp_data;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
   logic [3:0]  mem_wmask;

   int tests_run = 0;
   int tests_failed = 0;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_addr      (ifu_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_rsp_valid (lsu_rsp_valid),
      .rsp_data      (rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive_quiet();
      ifu_req_valid = 1'b0; ifu_addr = 32'h0;
      lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
      lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive_quiet();
      step();
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hFFFF_FFFF;
      #1;
      tests_run++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin tests_failed++; $display("FAIL rst_ready: got %b want 00", {ifu_req_ready, lsu_req_ready}); end
      tests_run++; if ({ifu_rsp_valid, lsu_rsp_valid, rsp_data} !== 34'h0) begin tests_failed++; $display("FAIL rst_rsp: got %b%b %h want 0", ifu_rsp_valid, lsu_rsp_valid, rsp_data); end
      tests_run++; if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== 70'h0) begin tests_failed++; $display("FAIL rst_mem: got v=%b a=%h", mem_req_valid, mem_addr); end
      step();
      drive_quiet();
      reset = 1'b1;
      step();
   endtask

   task automatic test_ifu_fetch();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
      #1;
      tests_run++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin tests_failed++; $display("FAIL ifu_grant: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
      step();
      ifu_req_valid = 1'b0;
      #1;
      tests_run++; if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0000}) begin tests_failed++; $display("FAIL ifu_memreq: got v=%b a=%h want 1 80000000", mem_req_valid, mem_addr); end
      tests_run++; if ({mem_wen, mem_wdata, mem_wmask} !== 37'h0) begin tests_failed++; $display("FAIL ifu_memfields: got wen=%b wd=%h wm=%b want 0", mem_wen, mem_wdata, mem_wmask); end
      tests_run++; if (ifu_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ifu_rsp_early: got %b want 0", ifu_rsp_valid); end
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
      #1;
      tests_run++; if ({ifu_rsp_valid, lsu_rsp_valid, rsp_data} !== {2'b10, 32'h0000_0413}) begin tests_failed++; $display("FAIL ifu_rsp: got %b%b %h want 10 00000413", ifu_rsp_valid, lsu_rsp_valid, rsp_data); end
      tests_run++; if ({mem_req_valid, mem_addr} !== 33'h0) begin tests_failed++; $display("FAIL ifu_wait_mem: got v=%b a=%h want 0", mem_req_valid, mem_addr); end
      step();
      drive_quiet();
      #1;
      tests_run++; if ({ifu_rsp_valid, rsp_data} !== 33'h0) begin tests_failed++; $display("FAIL ifu_rsp_pulse: got %b %h want 0", ifu_rsp_valid, rsp_data); end
   endtask

   task automatic test_stray_rsp();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA_5555;
      #1;
      tests_run++; if ({ifu_rsp_valid, lsu_rsp_valid, rsp_data} !== 34'h0) begin tests_failed++; $display("FAIL idle_stray_rsp: got %b%b %h want 0", ifu_rsp_valid, lsu_rsp_valid, rsp_data); end
      step();
      mem_rsp_valid = 1'b0;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0040;
      #1;
      tests_run++; if (lsu_req_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_after_stray: got ready=%b want 1", lsu_req_ready); end
      step();
      lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1;
      #1;
      tests_run++; if ({lsu_rsp_valid, mem_req_valid} !== 2'b01) begin tests_failed++; $display("FAIL req_stray_rsp: got rsp=%b memv=%b want 0 1", lsu_rsp_valid, mem_req_valid); end
      step();
      mem_rsp_valid = 1'b0;
      #1;
      tests_run++; if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0000_0040}) begin tests_failed++; $display("FAIL req_hold_stray: got v=%b a=%h want 1 00000040", mem_req_valid, mem_addr); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_1234;
      #1;
      tests_run++; if ({lsu_rsp_valid, rsp_data} !== {1'b1, 32'h0000_1234}) begin tests_failed++; $display("FAIL stray_load_rsp: got %b %h want 1 00001234", lsu_rsp_valid, rsp_data); end
      step();
      drive_quiet();
   endtask

   task automatic test_priority();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      tests_run++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin tests_failed++; $display("FAIL tie_grant: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
      step();
      lsu_req_valid = 1'b0;
      #1;
      tests_run++; if ({ifu_req_ready, mem_addr} !== {1'b0, 32'h8000_2000}) begin tests_failed++; $display("FAIL tie_req: got ifu_rdy=%b a=%h want 0 80002000", ifu_req_ready, mem_addr); end
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001;
      #1;
      tests_run++; if ({lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready, rsp_data} !== {3'b100, 32'hCAFE_0001}) begin tests_failed++; $display("FAIL tie_lsu_rsp: got %b%b%b %h want 100 cafe0001", lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready, rsp_data); end
      step();
      mem_rsp_valid = 1'b0;
      #1;
      tests_run++; if (ifu_req_ready !== 1'b1) begin tests_failed++; $display("FAIL tie_ifu_next: got %b want 1", ifu_req_ready); end
      step();
      ifu_req_valid = 1'b0;
      #1;
      tests_run++; if (mem_addr !== 32'h8000_0004) begin tests_failed++; $display("FAIL tie_ifu_addr: got %h want 80000004", mem_addr); end
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
      #1;
      tests_run++; if ({ifu_rsp_valid, rsp_data} !== {1'b1, 32'h0000_0013}) begin tests_failed++; $display("FAIL tie_ifu_rsp: got %b %h want 1 00000013", ifu_rsp_valid, rsp_data); end
      step();
      drive_quiet();
   endtask

   task automatic test_store_stall();
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = MASK_W;
      #1;
      tests_run++; if (lsu_req_ready !== 1'b1) begin tests_failed++; $display("FAIL st_grant: got %b want 1", lsu_req_ready); end
      step();
      drive_quiet();
      for (int c = 0; c < 4; c++) begin
         mem_req_ready = (c == 3);
         #1;
         tests_run++; if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 4'b1111}) begin tests_failed++; $display("FAIL st_hold c%0d: got v=%b w=%b a=%h d=%h m=%b", c, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask); end
         step();
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
      #1;
      tests_run++; if ({lsu_rsp_valid, ifu_rsp_valid, rsp_data} !== {2'b10, 32'h0}) begin tests_failed++; $display("FAIL st_ack: got %b%b %h want 10 00000000", lsu_rsp_valid, ifu_rsp_valid, rsp_data); end
      tests_run++; if ({mem_req_valid, mem_wen, mem_wdata, mem_wmask} !== 38'h0) begin tests_failed++; $display("FAIL st_wait_mem: got v=%b w=%b d=%h m=%b want 0", mem_req_valid, mem_wen, mem_wdata, mem_wmask); end
      step();
      drive_quiet();
   endtask

   task automatic test_reset_mid();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100; mem_req_ready = 1'b1;
      step();
      ifu_req_valid = 1'b0;
      step();
      mem_req_ready = 1'b0;
      reset = 1'b0;
      #1;
      tests_run++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_addr} !== 35'h0) begin tests_failed++; $display("FAIL midrst_out: got %b%b%b %h want 0", ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_addr); end
      step();
      reset = 1'b1;
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
      #1;
      tests_run++; if ({ifu_rsp_valid, lsu_rsp_valid, rsp_data} !== 34'h0) begin tests_failed++; $display("FAIL midrst_late_rsp: got %b%b %h want 0", ifu_rsp_valid, lsu_rsp_valid, rsp_data); end
      step();
      mem_rsp_valid = 1'b0;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b1;
      lsu_wdata = 32'h0000_00A5; lsu_wmask = MASK_B; mem_req_ready = 1'b1;
      #1;
      tests_run++; if (lsu_req_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_idle: got ready=%b want 1", lsu_req_ready); end
      step();
      lsu_req_valid = 1'b0;
      #1;
      tests_run++; if ({mem_addr, mem_wdata, mem_wmask} !== {32'h8000_0200, 32'h0000_00A5, 4'b0001}) begin tests_failed++; $display("FAIL midrst_sb: got a=%h d=%h m=%b", mem_addr, mem_wdata, mem_wmask); end
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
      #1;
      tests_run++; if ({lsu_rsp_valid, rsp_data} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL midrst_ack: got %b %h want 1 0", lsu_rsp_valid, rsp_data); end
      step();
      drive_quiet();
   endtask

   initial begin
      test_reset();
      test_ifu_fetch();
      test_stray_rsp();
      test_priority();
      test_store_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
